// File: rtl/iter_pkg.sv
// Shared definitions for the iterator family.
//
// Contents:
//   iter_state_t - two-state run control (IDLE, RUN) used by the iterators.
//   iter_clamp   - limits a start value to a maximum. Callers zero-extend
//                  their operands, so one function serves every width.
package iter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } iter_state_t;

  // Returns value, or max_value when value is larger. Both operands are
  // unsigned and are compared at their full width.
  function automatic logic [31:0] iter_clamp(input logic [31:0] value,
                                             input logic [31:0] max_value);
    return (value > max_value) ? max_value : value;
  endfunction

endpackage

// File: rtl/iter_countdown.sv
// Runtime-loadable down-counting iterator.
//
// A producer loads a start value through a valid/ready handshake. Start
// values above MAX_VALUE are clamped to MAX_VALUE. Each cycle that `dec` is
// high while a run is active, `val` steps down by one. `abort` ends a run
// immediately, and it has priority over `dec`.
//
// Build option: ITER_COUNTDOWN_RELOAD_EN
//   When defined, `dec` at val==0 reloads the stored start value and the run
//   continues, so the count wraps around.
//   When undefined, `dec` at val==0 ends the run. The block returns to IDLE
//   with val=0, so each load gives a single-shot run.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   load_valid in   producer offers a start value
//   load_val   in   start value, sampled only on a handshake [WIDTH]
//   load_ready out  high only in IDLE
//   dec        in   step request, one decrement per cycle it is high
//   abort      in   end the current run and return to IDLE
//   val        out  current iterator value [WIDTH]
//   done       out  busy and val==0
//   busy       out  a run is in progress
module iter_countdown
  import iter_pkg::*;
#(
  parameter int MAX_VALUE = 10,
  parameter int WIDTH     = $clog2(MAX_VALUE + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_val,
  output logic             load_ready,
  input  logic             dec,
  input  logic             abort,
  output logic [WIDTH-1:0] val,
  output logic             done,
  output logic             busy
);

  // The clamp compare uses WIDTH+1 bits so that MAX_VALUE is always
  // representable, even when it equals the largest WIDTH-bit value.
  localparam logic [WIDTH:0] MAX_EXT = (WIDTH + 1)'(MAX_VALUE);

  iter_state_t      state_q, state_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH:0]   load_ext;
  logic [WIDTH-1:0] load_clamped;

  assign load_ext     = {1'b0, load_val};
  assign load_clamped = WIDTH'(iter_clamp(32'(load_ext), 32'(MAX_EXT)));

  // Outputs are decoded from registers only. No input reaches an output
  // combinationally.
  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q == RUN);
  assign done       = busy && (val_q == '0);
  assign val        = val_q;

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    start_d = start_q;
    case (state_q)
      IDLE: begin
        // In IDLE, dec and abort are ignored. A load always wins.
        if (load_valid) begin
          start_d = load_clamped;
          val_d   = load_clamped;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          val_d   = '0;
        end else if (dec) begin
          // The zero case is decoded before the subtract, so val never wraps
          // below zero.
          if (val_q != '0) begin
            val_d = val_q - WIDTH'(1);
          end else begin
`ifdef ITER_COUNTDOWN_RELOAD_EN
            val_d = start_q;
`else
            state_d = IDLE;
            val_d   = '0;
`endif
          end
        end
      end
      default: begin
        state_d = IDLE;
        val_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      val_q   <= '0;
      start_q <= '0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      start_q <= start_d;
    end
  end

endmodule

// File: doc/iter_countdown.md
Name: iter_countdown

Overview:
- Runtime-loadable down-counting iterator: the decrementing counterpart of the fixed up-counting iterator.
- A producer loads a start value through a valid/ready handshake. The consumer then steps the value down by one per `dec` pulse until it reaches zero.
- Used wherever a loop runs a programmable number of steps from the top down: row/column countdowns, burst lengths, retry counts.

Parameters:
- MAX_VALUE, 10, largest legal start value; loads above it are clamped to it.
- WIDTH, $clog2(MAX_VALUE + 1), width of `val` and `load_val`.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_valid  in  1  producer offers a start value.
- load_val  in  WIDTH  start value; sampled only on handshake.
- load_ready  out  1  block can accept a start value (high only in IDLE).
- dec  in  1  step request; one decrement per cycle it is high.
- abort  in  1  terminate the current run; return to IDLE.
- val  out  WIDTH  current iterator value.
- done  out  1  high while busy and `val` == 0.
- busy  out  1  a run is in progress.

Behaviour:
- Clock and reset: one clock `clk`. `reset` is asynchronous and active-high.
- Reset (asserted at any time, including mid-run):
  - state=IDLE, val=0, start register=0.
  - done=0, busy=0, load_ready=1.
  - Outputs go to these values immediately, with no clock edge needed.
- States: IDLE, RUN. All outputs are combinational decodes of registers; no input-to-output combinational path.
  - load_ready = (state==IDLE)
  - busy = (state==RUN)
  - done = busy && (val==0)
- IDLE:
  - `dec` is ignored; `val` holds its last value (0 after reset or abort).
  - On load_valid && load_ready at an edge: start = min(load_val, MAX_VALUE), val = start, state goes to RUN.
  - Latency: `val` and `busy` are visible the cycle after the handshake.
- RUN:
  - `load_valid` is ignored (load_ready=0); no queuing of loads.
  - dec with val>0: val = val-1 at the next edge.
  - dec with val==0: end-of-run behaviour (see Optional Feature).
  - A start value of 0 is legal: done=1 in the first RUN cycle.
- Priority:
  - In RUN: abort > dec.
  - abort in RUN: next edge state=IDLE, val=0.
  - abort in IDLE: no effect.
  - abort and load_valid together in IDLE: the load is taken.
- Arithmetic:
  - Decrement is WIDTH-bit and never underflows; the val==0 case is decoded before subtracting.
  - Clamp is a WIDTH+1-bit compare against MAX_VALUE.
- `dec` held high steps `val` once per cycle.

Optional Feature:
- Macro: ITER_COUNTDOWN_RELOAD_EN.
- Defined: dec at val==0 reloads val=start and stays in RUN, giving wrap-around. done drops the next cycle unless start==0, in which case done stays 1.
- Undefined: dec at val==0 goes to IDLE with val=0, done=0, busy=0, load_ready=1. This is a single-shot run.
- `abort` behaves identically in both builds.

Decomposition:
- Shared package `iter_pkg`:
  - state enum `iter_state_t` {IDLE, RUN}
  - function `iter_clamp` (load value to MAX_VALUE) for reuse by other iterators
- No sub-module. The single always_ff state/val register block plus a combinational next-state block suffices.
- Expected size: ~150 lines.

Test Plan:
1. Reset and idle:
   - Stimulus: assert reset mid-run with val=5, then release.
   - Response: val=0, busy=0, done=0, load_ready=1 immediately. `dec` pulses in IDLE leave val=0.
2. Load and count:
   - Stimulus: load_val=4 handshake, then 5 single-cycle dec pulses with idle cycles between.
   - Response: val 4,3,2,1,0; done=1 only at 0.
   - Fifth dec, no macro: IDLE, load_ready=1.
   - Fifth dec, macro defined: val=4, busy=1.
3. Clamp and zero:
   - load_val=15 (MAX_VALUE=10, WIDTH=4) -> val=10.
   - load_val=0 -> done=1 in the first busy cycle.
4. Handshake rules:
   - load_valid held high during RUN with load_val=7 -> ignored (load_ready=0, val unchanged).
   - Accepted only after the run ends (no-macro build).
5. Abort priority:
   - Stimulus: in RUN at val=6, abort=1 and dec=1 in the same cycle.
   - Response: next cycle state IDLE, val=0 (not 5), busy=0.
6. Back-to-back:
   - Stimulus: dec held high continuously from val=3.
   - Response: val 3,2,1,0 on consecutive cycles, then per the build: IDLE (no macro) or val=3 (macro defined).
